// File: rtl/titan_mem_stage.sv
// Memory-access stage: turns EX/MEM load/store flags into one registered data-port
// transaction, extracts/extends load data and raises misalignment and bus-fault exceptions.
module titan_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_result,
  input  logic [31:0]       mem_store_data,
  input  logic [5:0]        mem_mem_flags,
  input  logic              mem_we,
  input  logic              kill,
  output logic [ADDR_W-1:0] dport_address,
  output logic [31:0]       dport_data_o,
  output logic [3:0]        dport_sel,
  output logic              dport_we,
  output logic              dport_enable,
  input  logic [31:0]       dport_data_i,
  input  logic              dport_ready,
  input  logic              dport_error,
  output logic              mem_stall,
  output logic [31:0]       mem_data_out,
  output logic              mem_we_out,
  output logic              exc_load_misaligned,
  output logic              exc_store_misaligned,
  output logic              exc_load_fault,
  output logic              exc_store_fault,
  output logic [1:0]        fsm_state
);

  // Data-port handshake: dport_enable rises with all dport_* outputs registered and
  // holds them stable until the cycle in which dport_ready or dport_error is high;
  // that edge ends the transaction (error is a completion, not a retry request).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  state_t state;
  state_t state_next;

  logic       rd;
  logic       wr;
  logic [1:0] width;
  logic       misaligned;
  logic       req;
  logic [3:0] sel_next;
  logic [31:0] data_next;

  logic        lat_rd;
  logic        lat_wr;
  logic [1:0]  lat_width;
  logic        lat_sign;
  logic [1:0]  lat_off;
  logic        killed;
  logic [31:0] lat_data;
  logic        lat_err;

  logic [31:0] shifted;
  logic [31:0] load_ext;

  logic is_idle;
  logic is_busy;
  logic is_done;
  logic done_live;

  assign rd = mem_mem_flags[0] & ~mem_mem_flags[1];
  assign wr = mem_mem_flags[1] & ~mem_mem_flags[0];

  always_comb begin
    width = W_WORD;
    if (mem_mem_flags[4])      width = W_WORD;
    else if (mem_mem_flags[3]) width = W_HALF;
    else if (mem_mem_flags[2]) width = W_BYTE;
  end

  always_comb begin
    misaligned = 1'b0;
    case (width)
      W_HALF:  misaligned = mem_result[0];
      W_WORD:  misaligned = |mem_result[1:0];
      default: misaligned = 1'b0;
    endcase
    misaligned = misaligned & (rd | wr);
  end

  assign req = (rd | wr) & ~misaligned & ~kill;

  always_comb begin
    sel_next  = 4'b1111;
    data_next = mem_store_data;
    case (width)
      W_BYTE: begin
        sel_next  = 4'b0001 << mem_result[1:0];
        data_next = {4{mem_store_data[7:0]}};
      end
      W_HALF: begin
        sel_next  = mem_result[1] ? 4'b1100 : 4'b0011;
        data_next = {2{mem_store_data[15:0]}};
      end
      default: begin
        sel_next  = 4'b1111;
        data_next = mem_store_data;
      end
    endcase
  end

  // Extraction uses the offset/width captured at request time, not the live pipeline inputs.
  assign shifted = dport_data_i >> {lat_off, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (lat_width)
      W_BYTE:  load_ext = {{24{lat_sign & shifted[7]}}, shifted[7:0]};
      W_HALF:  load_ext = {{16{lat_sign & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (dport_ready | dport_error) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dport_address <= '0;
      dport_data_o  <= '0;
      dport_sel     <= '0;
      dport_we      <= 1'b0;
      dport_enable  <= 1'b0;
      lat_rd        <= 1'b0;
      lat_wr        <= 1'b0;
      lat_width     <= '0;
      lat_sign      <= 1'b0;
      lat_off       <= '0;
      killed        <= 1'b0;
      lat_data      <= '0;
      lat_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            dport_address <= ADDR_W'(mem_result);
            dport_we      <= wr;
            dport_sel     <= sel_next;
            dport_data_o  <= data_next;
            dport_enable  <= 1'b1;
            lat_rd        <= rd;
            lat_wr        <= wr;
            lat_width     <= width;
            lat_sign      <= mem_mem_flags[5];
            lat_off       <= mem_result[1:0];
            killed        <= 1'b0;
          end
        end
        BUSY: begin
          if (kill) killed <= 1'b1;
          if (dport_ready | dport_error) begin
            dport_enable <= 1'b0;
            lat_data     <= load_ext;
            lat_err      <= dport_error;
          end
        end
        DONE: begin
          if (kill) killed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign is_idle   = (state == IDLE);
  assign is_busy   = (state == BUSY);
  assign is_done   = (state == DONE);
  assign done_live = is_done & ~killed & ~kill;
  assign fsm_state = state;

  assign mem_stall = (is_idle & req) | is_busy;

  assign exc_load_misaligned  = is_idle & misaligned & rd & ~kill;
  assign exc_store_misaligned = is_idle & misaligned & wr & ~kill;
  assign exc_load_fault       = done_live & lat_err & lat_rd;
  assign exc_store_fault      = done_live & lat_err & lat_wr;

  assign mem_data_out = (is_done & lat_rd) ? lat_data : mem_result;

  // A killed access still finishes on the bus but must not retire a register write.
  assign mem_we_out = mem_we & ~kill & ~(is_done & killed)
                    & ~(exc_load_misaligned | exc_store_misaligned
                        | exc_load_fault | exc_store_fault);

endmodule
